// File: rtl/pc_sequencer_if.sv
// Handshake and control bundle between the PC sequencer, instruction memory,
// execute stage and the programCounter block.
interface pc_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic        fetch_valid;
  logic        exec_done;
  logic [1:0]  br_kind;
  logic        cond_flag;
  logic [31:0] br_offset;
  logic [31:0] jr_target;
  logic        halt_req;
  logic        stall;
  logic [1:0]  ps;
  logic [31:0] pc_in;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  modport master (
    output imem_req, fetch_valid, ps, pc_in, halted, fault, retired,
    input  imem_ack, exec_done, br_kind, cond_flag, br_offset, jr_target,
           halt_req, stall
  );

  modport slave (
    input  imem_req, fetch_valid, ps, pc_in, halted, fault, retired,
    output imem_ack, exec_done, br_kind, cond_flag, br_offset, jr_target,
           halt_req, stall
  );
endinterface

// File: rtl/pc_sequencer.sv
// Boot / fetch / execute / update sequencer; sole driver of the programCounter
// function select and load value.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 15
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.master bus
);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_EXEC, S_UPDATE, S_HALT, S_FAULT
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait;
  logic        r_fetch_valid;
  logic [1:0]  r_kind;
  logic        r_flag;
  logic [31:0] r_off;
  logic [31:0] r_tgt;
  logic [31:0] r_retired;

  logic [1:0]  w_ps;
  logic [31:0] w_pc_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_wait        <= '0;
      r_fetch_valid <= 1'b0;
      r_kind        <= 2'b00;
      r_flag        <= 1'b0;
      r_off         <= '0;
      r_tgt         <= '0;
      r_retired     <= '0;
    end else begin
      r_fetch_valid <= 1'b0;
      unique case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          r_wait  <= '0;
        end
        S_FETCH: begin
          // ack wins over a timeout landing in the same cycle
          if (bus.imem_ack) begin
            r_state       <= S_EXEC;
            r_fetch_valid <= 1'b1;
          end else if (r_wait == TO) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            r_kind    <= bus.br_kind;
            r_flag    <= bus.cond_flag;
            r_off     <= bus.br_offset;
            r_tgt     <= bus.jr_target;
            r_retired <= r_retired + 32'd1;
            r_state   <= bus.halt_req ? S_HALT : S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!bus.stall) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // stall is the one input allowed to reach ps: it must suppress the update
  // in the very cycle it is high, otherwise the PC would advance early.
  always_comb begin
    w_ps    = 2'b00;
    w_pc_in = '0;
    unique case (r_state)
      S_BOOT: begin
        w_ps    = 2'b10;
        w_pc_in = RESET_VECTOR;
      end
      S_UPDATE: begin
        if (!bus.stall) begin
          unique case (r_kind)
            2'b00: w_ps = 2'b01;
            2'b01: begin
              if (r_flag) begin
                w_ps    = 2'b11;
                w_pc_in = r_off;
              end else begin
                w_ps = 2'b01;
              end
            end
            2'b10: begin
              w_ps    = 2'b11;
              w_pc_in = r_off;
            end
            default: begin
              w_ps    = 2'b10;
              w_pc_in = r_tgt;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.ps          = w_ps;
  assign bus.pc_in       = w_pc_in;
  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.fault       = (r_state == S_FAULT);
  assign bus.retired     = r_retired;
endmodule
